// File: rtl/mult_arb_pkg.sv
// Shared widths, controller states and tag-width helper for the mult_arb slice.
// Optional feature macro: MULT_ARB_PRIO0_EN (requester 0 strict priority).
package mult_arb_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // Tag/pointer width for n requesters; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mult_arb_rr_arbiter.sv
// Round-robin grant: first requesting index at or above ptr, wrapping.
// With MULT_ARB_PRIO0_EN defined, requester 0 wins outright whenever it requests.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [N-1:0]  rr_req;
  logic [PW-1:0] cand_idx;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    cand_idx = '0;
`ifdef MULT_ARB_PRIO0_EN
    rr_req = {req[N-1:1], 1'b0};
`else
    rr_req = req;
`endif
    for (int off = 0; off < N; off++) begin
      cand_idx = PW'((int'(ptr) + off) % N);
      if (!gnt_any && rr_req[cand_idx]) begin
        gnt_any       = 1'b1;
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
      end
    end
`ifdef MULT_ARB_PRIO0_EN
    if (req[0]) begin
      gnt     = N'(1);
      gnt_idx = '0;
      gnt_any = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/mult_arb.sv
// Arbitrates NUM_REQ requesters onto one external pipelined multiplier and
// routes each product back by tag. Optional macro: MULT_ARB_PRIO0_EN.
// Handshake: a requester transfers in any cycle where req_valid[i] && req_ready[i];
// req_ready depends on req_valid combinationally and carries no other promise.
module mult_arb
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [OP_W*NUM_REQ-1:0] req_a,
  input  logic [OP_W*NUM_REQ-1:0] req_b,
  output logic [OP_W-1:0]         mul_a,
  output logic [OP_W-1:0]         mul_b,
  input  logic [PROD_W-1:0]       mul_res,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [PROD_W-1:0]       rsp_data,
  input  logic                    drain,
  output logic                    busy,
  output logic                    halted
);

  localparam int TW = clog2(NUM_REQ);

  state_e                     state_q, state_d;
  logic [TW-1:0]              ptr_q, ptr_d;
  logic [MUL_LAT-1:0]         pv_q, pv_d;
  logic [MUL_LAT-1:0][TW-1:0] pt_q, pt_d;
  logic [NUM_REQ-1:0]         rsp_valid_q, rsp_valid_d;
  logic [PROD_W-1:0]          rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] gnt;
  logic [TW-1:0]      gnt_idx;
  logic               gnt_any;

  assign arb_req = (state_q == ST_RUN && !drain) ? req_valid : '0;

  rr_arbiter #(.N(NUM_REQ), .PW(TW)) u_arb (
    .req     (arb_req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;
  assign mul_a     = gnt_any ? req_a[OP_W*gnt_idx +: OP_W] : '0;
  assign mul_b     = gnt_any ? req_b[OP_W*gnt_idx +: OP_W] : '0;
  assign busy      = (|pv_q) | (|rsp_valid_q);
  assign halted    = (state_q == ST_HALT);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == TW'(NUM_REQ - 1)) ? '0 : gnt_idx + TW'(1);
`ifdef MULT_ARB_PRIO0_EN
    if (gnt[0]) ptr_d = ptr_q;
`endif
  end

  // Tag pipe tracks the multiplier latency so mul_res lines up with its tag.
  always_comb begin
    pv_d[0] = gnt_any;
    pt_d[0] = gnt_idx;
    for (int i = 1; i < MUL_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pt_d[i] = pt_q[i-1];
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (pv_q[MUL_LAT-1]) begin
      rsp_valid_d[pt_q[MUL_LAT-1]] = 1'b1;
      rsp_data_d                   = mul_res;
    end
  end

  // A drain request always completes through HALT, even if drain drops early.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (drain) state_d = ST_DRAIN;
      ST_DRAIN: if (!busy) state_d = ST_HALT;
      ST_HALT:  if (!drain) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      ptr_q       <= '0;
      pv_q        <= '0;
      pt_q        <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      pv_q        <= pv_d;
      pt_q        <= pt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_mult_arb.sv
// Randomized and directed bench for mult_arb with an external pipelined multiplier model.
// Build with +define+MULT_ARB_PRIO0_EN to exercise the requester-0 priority mode.
module tb_mult_arb;

  localparam int N = 4;
  localparam int L = 3;
  localparam int W = 50;  // {due cycle[31:0], tag[1:0], product[15:0]}

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [8*N-1:0] req_a = '0;
  logic [8*N-1:0] req_b = '0;
  logic [7:0]     mul_a, mul_b;
  logic [15:0]    mul_res;
  logic [N-1:0]   rsp_valid;
  logic [15:0]    rsp_data;
  logic           drain = 1'b0;
  logic           busy, halted;

  logic [15:0] mpipe [L] = '{default: 16'h0000};
  logic [W-1:0] exp_q[$];

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   m_ptr = 0;
  int   m_st = 0;          // 0 RUN, 1 DRAIN, 2 HALT
  int   last_grant = -1000;
  bit   clr_pending = 1'b0;
  bit   mon_en = 1'b0;
  logic [15:0] last_data = 16'h0000;

  mult_arb #(.NUM_REQ(N), .MUL_LAT(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_res   (mul_res),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .drain     (drain),
    .busy      (busy),
    .halted    (halted)
  );

  // ---------------- clock / cycle counter / multiplier model ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    mpipe[0] <= 16'(mul_a) * 16'(mul_b);
    for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_res = mpipe[L-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver + reference model ----------------
  task automatic step(input logic [N-1:0] v, input logic [8*N-1:0] a,
                      input logic [8*N-1:0] b, input logic d, input logic r);
    int   w;
    int   pa, pb;
    logic m_busy;
    @(posedge clk);
    if (clr_pending) begin
      exp_q.delete();
      last_data   = 16'h0000;
      clr_pending = 1'b0;
    end
    #1;
    req_valid = v; req_a = a; req_b = b; drain = d; reset = r;
    @(negedge clk);
    // a product is in flight from its accept cycle until its response cycle
    m_busy = (last_grant >= cyc - L - 1);
    if (r) begin
      m_ptr = 0; m_st = 0; last_grant = -1000; clr_pending = 1'b1;
    end else begin
      w = -1;
      if (m_st == 0 && !d) begin
`ifdef MULT_ARB_PRIO0_EN
        if (v[0]) w = 0;
`endif
        for (int off = 0; off < N; off++) begin
          int i = (m_ptr + off) % N;
`ifdef MULT_ARB_PRIO0_EN
          if (w < 0 && i != 0 && v[i]) w = i;
`else
          if (w < 0 && v[i]) w = i;
`endif
        end
      end
      chk("req_ready", req_ready, (w >= 0) ? (64'd1 << w) : 64'd0);
      chk("halted", halted, (m_st == 2) ? 64'd1 : 64'd0);
      chk("busy", busy, m_busy ? 64'd1 : 64'd0);
      if (w >= 0) begin
        pa = int'(a[8*w +: 8]);
        pb = int'(b[8*w +: 8]);
        chk("mul_a", mul_a, 64'(pa));
        chk("mul_b", mul_b, 64'(pb));
        exp_q.push_back({32'(cyc + L + 1), 2'(w), 16'(pa * pb)});
        last_grant = cyc;
`ifdef MULT_ARB_PRIO0_EN
        if (w != 0) m_ptr = (w + 1) % N;
`else
        m_ptr = (w + 1) % N;
`endif
      end else begin
        chk("mul_idle", {mul_a, mul_b}, 64'd0);
      end
      case (m_st)
        0: if (d) m_st = 1;
        1: if (!m_busy) m_st = 2;
        default: if (!d) m_st = 0;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rsp_valid != '0) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", rsp_valid, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_cycle", 64'(cyc), 64'(e[49:18]));
            chk("rsp_tag", rsp_valid, 64'd1 << e[17:16]);
            chk("rsp_data", rsp_data, 64'(e[15:0]));
            last_data = e[15:0];
          end
        end else begin
          chk("rsp_hold", rsp_data, 64'(last_data));
          if (exp_q.size() > 0 && int'(exp_q[0][49:18]) <= cyc) begin
            e = exp_q.pop_front();
            chk("rsp_missing", rsp_valid, 64'd1 << e[17:16]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [8*N-1:0] a, b;
    step('0, '0, '0, 1'b0, 1'b1);
    step('0, '0, '0, 1'b0, 1'b1);
    idle(1);
    chk("reset_rsp_valid", rsp_valid, 64'd0);
    chk("reset_rsp_data", rsp_data, 64'd0);
    mon_en = 1'b1;
    idle(2);

    // single request, product 120
    step(4'b0001, {24'd0, 8'd12}, {24'd0, 8'd10}, 1'b0, 1'b0);
    idle(6);

    // four requesters back-to-back from ptr 0
    step('0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) step(4'hF, $urandom, $urandom, 1'b0, 1'b0);
    idle(6);

    // operand boundaries
    step(4'b1000, 32'hFF00_0000, 32'hFF00_0000, 1'b0, 1'b0);
    step(4'b0100, 32'h0000_0000, 32'h007F_0000, 1'b0, 1'b0);
    step(4'b0010, 32'h0000_FF00, 32'h0000_0100, 1'b0, 1'b0);
    idle(6);

    // drain with three in flight, then resume
    for (int k = 0; k < 3; k++) step(4'hF, $urandom, $urandom, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(4'hF, $urandom, $urandom, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(4'hF, $urandom, $urandom, 1'b0, 1'b0);
    idle(6);

    // drain pulse released while products are still in flight
    for (int k = 0; k < 2; k++) step(4'hF, $urandom, $urandom, 1'b0, 1'b0);
    step(4'hF, $urandom, $urandom, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) step(4'hF, $urandom, $urandom, 1'b0, 1'b0);
    idle(6);

    // reset with two in flight, next grant from lowest valid index
    for (int k = 0; k < 2; k++) step(4'hF, $urandom, $urandom, 1'b0, 1'b0);
    step('0, '0, '0, 1'b0, 1'b1);
    step(4'b1010, $urandom, $urandom, 1'b0, 1'b0);
    idle(6);

`ifdef MULT_ARB_PRIO0_EN
    for (int k = 0; k < 4; k++) step(4'b0101, $urandom, $urandom, 1'b0, 1'b0);
    step(4'b0100, $urandom, $urandom, 1'b0, 1'b0);
    idle(6);
`endif

    // random traffic
    for (int k = 0; k < 400; k++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 9) == 0) a = '1;
      if ($urandom_range(0, 9) == 0) b = '1;
      step(N'($urandom_range(0, 15)), a, b,
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 149) == 0));
    end
    idle(12);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
